// File: rtl/maker_gpio_pkg.sv
// maker_gpio_pkg: shared LED mode and chaser direction types for the GPIO fabric
package maker_gpio_pkg;
   typedef enum logic [1:0] {
      MODE_PASS  = 2'b00,
      MODE_PWM   = 2'b01,
      MODE_CHASE = 2'b10,
      MODE_OFF   = 2'b11
   } mode_e;
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;
endpackage

// File: rtl/maker_btn_debounce.sv
// maker_btn_debounce: synchronise and debounce a raw button, emit level and rising-edge pulse
module maker_btn_debounce #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise
);
   localparam int CW = $clog2(DEB_CYCLES);
   logic [1:0]    sync_q;
   logic [CW-1:0] deb_cnt;
   logic          sync;
   logic          done;
   assign sync = sync_q[1];
   assign done = deb_cnt == CW'(DEB_CYCLES - 1);
   // synchroniser, stability counter and registered level/pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         deb_cnt <= '0;
         level   <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw};
         rise   <= sync & ~level & done;
         if (sync == level) deb_cnt <= '0;
         else if (done) begin
            level   <= sync;
            deb_cnt <= '0;
         end else deb_cnt <= deb_cnt + CW'(1);
      end
   end
endmodule

// File: rtl/maker_gpio_fabric.sv
// maker_gpio_fabric: LED pass/PWM/chaser engine with debounced button for the MSS
module maker_gpio_fabric
   import maker_gpio_pkg::*;
#(
   parameter int N_CH        = 8,
   parameter int PWM_W       = 8,
   parameter int STEP_CYCLES = 1000000,
   parameter int DEB_CYCLES  = 50000
) (
   input  logic                    FAB_CCC_GL0,
   input  logic                    FAB_RESET_N,
   input  logic [N_CH-1:0]         GPIO_M2F,
   input  logic [1:0]              MODE,
   input  logic [PWM_W-1:0]        DUTY,
   input  logic                    GPIO_8_F2M,
   output logic [N_CH-1:0]         LED_OUT,
   output logic                    BTN_LEVEL,
   output logic                    BTN_RISE,
   output logic [$clog2(N_CH)-1:0] CHASE_POS
);
   localparam int PW = $clog2(N_CH);
   localparam int SW = $clog2(STEP_CYCLES);
   mode_e            mode_q;
   dir_e             dir;
   dir_e             dir_eff;
   logic [PWM_W-1:0] pwm_cnt;
   logic [PWM_W-1:0] duty_q;
   logic [SW-1:0]    step_cnt;
   logic             enter;
   logic             tick;
   logic [PW-1:0]    pos_nxt;
   logic [N_CH-1:0]  onehot;
   logic [N_CH-1:0]  led_nxt;
   maker_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
      .clk   (FAB_CCC_GL0),
      .rst_n (FAB_RESET_N),
      .raw   (GPIO_8_F2M),
      .level (BTN_LEVEL),
      .rise  (BTN_RISE)
   );
   // chaser step decode; a coincident button rise steps in the toggled direction
   always_comb begin
      enter   = (MODE == MODE_CHASE) && (mode_q != MODE_CHASE);
      tick    = (mode_q == MODE_CHASE) && (step_cnt == SW'(STEP_CYCLES - 1));
      dir_eff = BTN_RISE ? dir_e'(~dir) : dir;
      pos_nxt = (dir_eff == DIR_UP) ? ((CHASE_POS == PW'(N_CH - 1)) ? '0 : CHASE_POS + 1'b1)
                                    : ((CHASE_POS == '0) ? PW'(N_CH - 1) : CHASE_POS - 1'b1);
      onehot  = N_CH'(1) << CHASE_POS;
      led_nxt = (mode_q == MODE_PASS)  ? GPIO_M2F :
                (mode_q == MODE_PWM)   ? (GPIO_M2F & {N_CH{pwm_cnt < duty_q}}) :
                (mode_q == MODE_CHASE) ? (GPIO_M2F & onehot) : '0;
   end
   // mode register, free-running PWM counter and period-aligned duty capture
   always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
      if (!FAB_RESET_N) begin
         mode_q  <= MODE_PASS;
         pwm_cnt <= '0;
         duty_q  <= '0;
      end else begin
         mode_q  <= mode_e'(MODE);
         pwm_cnt <= pwm_cnt + 1'b1;
         if (pwm_cnt == '1) duty_q <= DUTY;
      end
   end
   // chaser position, step timer and direction; entering chase restarts from 0 going up
   always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
      if (!FAB_RESET_N) begin
         CHASE_POS <= '0;
         step_cnt  <= '0;
         dir       <= DIR_UP;
      end else if (enter) begin
         CHASE_POS <= '0;
         step_cnt  <= '0;
         dir       <= DIR_UP;
      end else begin
         dir <= dir_eff;
         if (mode_q == MODE_CHASE) begin
            step_cnt <= tick ? '0 : step_cnt + 1'b1;
            if (tick) CHASE_POS <= pos_nxt;
         end
      end
   end
   // registered LED drive
   always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
      if (!FAB_RESET_N) LED_OUT <= '0;
      else LED_OUT <= led_nxt;
   end
endmodule

// File: tb/tb_maker_gpio_fabric.sv
// tb_maker_gpio_fabric: self-checking bench for the GPIO fabric
module tb_maker_gpio_fabric;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] gpio;
   logic [1:0] mode;
   logic [3:0] duty;
   logic       btn;
   logic [7:0] led;
   logic       lvl;
   logic       rise;
   logic [2:0] pos;
   int total = 0;
   int bad = 0;
   int rises = 0;
   int wide = 0;
   logic rise_d = 1'b0;
   typedef struct {logic [7:0] g; logic [7:0] e;} vec_t;
   vec_t pv[6];
   logic [7:0] sb[$];
   logic [2:0] pq[$];
   logic [2:0] cur;
   logic [7:0] prev;
   int n, n2, n3;
   logic found;
   maker_gpio_fabric #(.N_CH(8), .PWM_W(4), .STEP_CYCLES(4), .DEB_CYCLES(8)) dut (
      .FAB_CCC_GL0 (clk),
      .FAB_RESET_N (rst_n),
      .GPIO_M2F    (gpio),
      .MODE        (mode),
      .DUTY        (duty),
      .GPIO_8_F2M  (btn),
      .LED_OUT     (led),
      .BTN_LEVEL   (lvl),
      .BTN_RISE    (rise),
      .CHASE_POS   (pos)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (rise) rises <= rises + 1;
      if (rise && rise_d) wide <= wide + 1;
      rise_d <= rise;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic step_q();
      logic [2:0] nxt;
      nxt = pq.pop_front();
      repeat (3) @(negedge clk);
      chk("chase_hold", pos, cur);
      chk("chase_led", led, (8'h01 << cur) & gpio);
      @(negedge clk);
      chk("chase_step", pos, nxt);
      cur = nxt;
   endtask
   task automatic run_q();
      while (pq.size() > 0) step_q();
   endtask
   initial begin
      pv[0] = '{8'hA5, 8'hA5};
      pv[1] = '{8'h5A, 8'h5A};
      pv[2] = '{8'hFF, 8'hFF};
      pv[3] = '{8'h00, 8'h00};
      pv[4] = '{8'h3C, 8'h3C};
      pv[5] = '{8'h81, 8'h81};
      rst_n = 1'b0; gpio = '0; mode = 2'b00; duty = '0; btn = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_led", led, 0);
      chk("reset_lvl", lvl, 0);
      chk("reset_rise", rise, 0);
      chk("reset_pos", pos, 0);
      rst_n = 1'b1;
      prev = 8'h00;
      for (int i = 0; i < 6; i++) begin
         gpio = pv[i].g;
         sb.push_back(pv[i].e);
         #1 chk("pass_hold", led, prev);
         @(negedge clk);
         chk("pass", led, sb.pop_front());
         prev = pv[i].e;
      end
      #2 rst_n = 1'b0;
      #1 chk("async_reset_led", led, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mode = 2'b01; gpio = 8'hFF; duty = 4'd4;
      repeat (40) @(negedge clk);
      n = 0; n2 = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (led == 8'hFF) n++;
         if (led == 8'h00) n2++;
      end
      chk("pwm4_on", n, 8);
      chk("pwm4_off", n2, 24);
      found = 1'b0;
      prev = led;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (prev == 8'hFF && led == 8'h00) found = 1'b1;
         prev = led;
      end
      chk("pwm_fall_found", found, 1);
      duty = 4'd12;
      n = 0;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         if (led != 8'h00) n++;
      end
      chk("pwm_midperiod_old", n, 0);
      n = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 0) chk("pwm_new_start", led, 8'hFF);
         if (led == 8'hFF) n++;
      end
      chk("pwm_new_duty", n, 12);
      duty = 4'd0;
      repeat (20) @(negedge clk);
      n = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (led != 8'h00) n++;
      end
      chk("pwm_duty0", n, 0);
      gpio = 8'h0F; duty = 4'd15;
      repeat (20) @(negedge clk);
      n = 0; n2 = 0; n3 = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (led == 8'h0F) n++;
         if (led[7:4] != 4'h0) n2++;
         if (led == 8'h00) n3++;
      end
      chk("pwm_mask_on", n, 15);
      chk("pwm_mask_hi", n2, 0);
      chk("pwm_mask_off", n3, 1);
      n = 0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 10; c++) begin
            btn = (c < 5);
            @(negedge clk);
            if (lvl) n++;
         end
      end
      repeat (12) begin
         @(negedge clk);
         if (lvl) n++;
      end
      chk("deb_short_lvl", n, 0);
      chk("deb_short_rise", rises, 0);
      btn = 1'b1;
      n = 0;
      while (!lvl && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("deb_latency", n, 10);
      chk("deb_rise_with_level", rise, 1);
      @(negedge clk);
      chk("deb_rise_one_cycle", rise, 0);
      repeat (5) @(negedge clk);
      chk("deb_rise_count", rises, 1);
      btn = 1'b0;
      repeat (14) @(negedge clk);
      chk("deb_release_lvl", lvl, 0);
      chk("deb_release_no_rise", rises, 1);
      mode = 2'b10; gpio = 8'hFF;
      @(negedge clk);
      chk("chase_entry_pos", pos, 0);
      cur = 3'd0;
      for (int i = 1; i <= 8; i++) pq.push_back(3'(i));
      run_q();
      btn = 1'b1;
      pq.push_back(3'd1); pq.push_back(3'd2); pq.push_back(3'd1);
      pq.push_back(3'd0); pq.push_back(3'd7);
      run_q();
      btn = 1'b0;
      fork
         begin
            repeat (9) @(negedge clk);
            btn = 1'b1;
         end
      join_none
      pq.push_back(3'd6); pq.push_back(3'd5); pq.push_back(3'd4);
      pq.push_back(3'd3); pq.push_back(3'd4); pq.push_back(3'd5);
      run_q();
      chk("chase_rise_count", rises, 3);
      mode = 2'b00; gpio = 8'h3C;
      @(negedge clk);
      chk("mode_lat_old", led, 8'h20);
      @(negedge clk);
      chk("mode_lat_new", led, 8'h3C);
      repeat (6) @(negedge clk);
      chk("pass_pos_hold", pos, 5);
      btn = 1'b0;
      repeat (12) @(negedge clk);
      btn = 1'b1;
      repeat (12) @(negedge clk);
      chk("pass_rise_count", rises, 4);
      mode = 2'b10; gpio = 8'hFF;
      @(negedge clk);
      chk("reentry_pos", pos, 0);
      cur = 3'd0;
      pq.push_back(3'd1);
      run_q();
      mode = 2'b11;
      repeat (2) @(negedge clk);
      chk("off_led", led, 0);
      repeat (8) @(negedge clk);
      chk("off_pos_hold", pos, cur);
      chk("off_led_stay", led, 0);
      chk("rise_width", wide, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
